// File: rtl/ctrl_prog_ctr_stack_if.sv
// ctrl_prog_ctr_stack_if
//   Bundles the fetch-side program-counter signals of the 8-bit RISC/RNS core.
//   master: pipeline side (drives stall / r2 redirects, observes PC and RAS status)
//   slave : program counter block
//   Signals:
//     stall, branch_taken_reg, call_taken_reg, ret_taken_reg   redirect/hold controls
//     nxt_prog_ctr_r2, ret_addr_r2                             branch/call target, return addr
//     prog_ctr, set_invalidate_instruction                     fetch address, squash
//     stack_depth, stack_ovf, stack_unf                        RAS status
interface ctrl_prog_ctr_stack_if #(
   parameter int unsigned PROG_CTR_WID = 10,
   parameter int unsigned STACK_DEPTH  = 4
);
   localparam int unsigned DEPTH_WID = $clog2(STACK_DEPTH + 1);

   logic                    stall;
   logic                    branch_taken_reg;
   logic                    call_taken_reg;
   logic                    ret_taken_reg;
   logic [PROG_CTR_WID-1:0] nxt_prog_ctr_r2;
   logic [PROG_CTR_WID-1:0] ret_addr_r2;
   logic [PROG_CTR_WID-1:0] prog_ctr;
   logic                    set_invalidate_instruction;
   logic [DEPTH_WID-1:0]    stack_depth;
   logic                    stack_ovf;
   logic                    stack_unf;

   modport master (
      output stall, branch_taken_reg, call_taken_reg, ret_taken_reg,
      output nxt_prog_ctr_r2, ret_addr_r2,
      input  prog_ctr, set_invalidate_instruction, stack_depth, stack_ovf, stack_unf
   );

   modport slave (
      input  stall, branch_taken_reg, call_taken_reg, ret_taken_reg,
      input  nxt_prog_ctr_r2, ret_addr_r2,
      output prog_ctr, set_invalidate_instruction, stack_depth, stack_ovf, stack_unf
   );
endinterface

// File: rtl/ctrl_prog_ctr_stack.sv
// ctrl_prog_ctr_stack
//   Program counter for the fetch stage with stall hold, r2-resolved branch/call/return
//   redirects, an internal circular return-address stack and a multi-cycle flush.
//   Ports:
//     clk    rising-edge clock
//     reset  asynchronous active-high reset
//     bus    ctrl_prog_ctr_stack_if.slave (controls in, PC / invalidate / RAS status out)
//   Next-PC priority: ret > call > branch > stall > increment.
module ctrl_prog_ctr_stack #(
   parameter int unsigned             PROG_CTR_WID = 10,
   parameter logic [PROG_CTR_WID-1:0] RESET_VEC    = PROG_CTR_WID'(1),
   parameter int unsigned             STACK_DEPTH  = 4,
   parameter int unsigned             FLUSH_CYCLES = 2
) (
   input logic                  clk,
   input logic                  reset,
   ctrl_prog_ctr_stack_if.slave bus
);
   localparam int unsigned DEPTH_WID = $clog2(STACK_DEPTH + 1);
   localparam int unsigned PTR_WID   = $clog2(STACK_DEPTH);
   localparam int unsigned CNT_WID   = $clog2(FLUSH_CYCLES + 1);

   localparam logic [PTR_WID-1:0]   PTR_MAX    = PTR_WID'(STACK_DEPTH - 1);
   localparam logic [DEPTH_WID-1:0] DEPTH_FULL = DEPTH_WID'(STACK_DEPTH);
   localparam logic [CNT_WID-1:0]   CNT_LOAD   = CNT_WID'(FLUSH_CYCLES);

   logic [PROG_CTR_WID-1:0] pc_q, pc_d;
   logic [DEPTH_WID-1:0]    depth_q, depth_d;
   logic [PTR_WID-1:0]      ptr_q, ptr_d, ptr_inc, ptr_dec;
   logic [CNT_WID-1:0]      cnt_q, cnt_d;
   logic                    inv_q;
   logic                    ovf_q, ovf_d;
   logic                    unf_q, unf_d;
   logic                    push;
   logic                    redirect;
   logic                    ras_empty, ras_full;

   logic [PROG_CTR_WID-1:0] ras_q [STACK_DEPTH];

   assign ras_empty = (depth_q == '0);
   assign ras_full  = (depth_q == DEPTH_FULL);
   // Explicit wrap so non-power-of-two depths stay circular.
   assign ptr_inc   = (ptr_q == PTR_MAX) ? '0 : ptr_q + PTR_WID'(1);
   assign ptr_dec   = (ptr_q == '0) ? PTR_MAX : ptr_q - PTR_WID'(1);
   assign redirect  = bus.ret_taken_reg | bus.call_taken_reg | bus.branch_taken_reg;

   always_comb begin
      pc_d    = pc_q;
      depth_d = depth_q;
      ptr_d   = ptr_q;
      ovf_d   = ovf_q;
      unf_d   = unf_q;
      push    = 1'b0;
      if (bus.ret_taken_reg) begin
         if (ras_empty) begin
            pc_d  = RESET_VEC;
            unf_d = 1'b1;
         end else begin
            pc_d    = ras_q[ptr_dec];
            ptr_d   = ptr_dec;
            depth_d = depth_q - DEPTH_WID'(1);
         end
      end else if (bus.call_taken_reg) begin
         pc_d  = bus.nxt_prog_ctr_r2;
         push  = 1'b1;
         ptr_d = ptr_inc;
         // When full, ptr_q already points at the oldest entry, so the push overwrites it.
         if (ras_full) begin
            ovf_d = 1'b1;
         end else begin
            depth_d = depth_q + DEPTH_WID'(1);
         end
      end else if (bus.branch_taken_reg) begin
         pc_d = bus.nxt_prog_ctr_r2;
      end else if (!bus.stall) begin
         pc_d = pc_q + PROG_CTR_WID'(1);
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if (redirect) begin
         cnt_d = CNT_LOAD;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CNT_WID'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q    <= RESET_VEC;
         depth_q <= '0;
         ptr_q   <= '0;
         cnt_q   <= '0;
         inv_q   <= 1'b0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         pc_q    <= pc_d;
         depth_q <= depth_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         // Flop the decode so the squash is high exactly while the reloaded counter is non-zero.
         inv_q   <= (cnt_d != '0);
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   // RAS storage needs no reset; only entries below stack_depth are ever read.
   always_ff @(posedge clk) begin
      if (push) begin
         ras_q[ptr_q] <= bus.ret_addr_r2;
      end
   end

   assign bus.prog_ctr                   = pc_q;
   assign bus.set_invalidate_instruction = inv_q;
   assign bus.stack_depth                = depth_q;
   assign bus.stack_ovf                  = ovf_q;
   assign bus.stack_unf                  = unf_q;
endmodule

// File: tb/tb_ctrl_prog_ctr_stack.sv
// tb_ctrl_prog_ctr_stack
//   Directed scenarios followed by randomized traffic, every cycle compared against a
//   queue-based reference of the program counter, return stack and flush window.
module tb_ctrl_prog_ctr_stack;
   localparam int unsigned W     = 10;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned FLUSH = 2;
   localparam logic [W-1:0] RVEC = 10'd1;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   ctrl_prog_ctr_stack_if #(.PROG_CTR_WID(W), .STACK_DEPTH(DEPTH)) bus ();

   ctrl_prog_ctr_stack #(
      .PROG_CTR_WID(W),
      .RESET_VEC   (RVEC),
      .STACK_DEPTH (DEPTH),
      .FLUSH_CYCLES(FLUSH)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Reference state
   logic [W-1:0] m_pc;
   logic [W-1:0] m_ras[$];
   int           m_flush_left;
   logic         m_ovf, m_unf;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pc         = RVEC;
      m_ras.delete();
      m_flush_left = 0;
      m_ovf        = 1'b0;
      m_unf        = 1'b0;
   endtask

   task automatic model_edge(input logic st, input logic br, input logic ca, input logic rt,
                             input logic [W-1:0] nxt, input logic [W-1:0] ra);
      if (rt) begin
         if (m_ras.size() == 0) begin
            m_pc  = RVEC;
            m_unf = 1'b1;
         end else begin
            m_pc = m_ras.pop_back();
         end
      end else if (ca) begin
         m_pc = nxt;
         m_ras.push_back(ra);
         if (m_ras.size() > DEPTH) begin
            m_ras.delete(0);
            m_ovf = 1'b1;
         end
      end else if (br) begin
         m_pc = nxt;
      end else if (!st) begin
         m_pc = W'((int'(m_pc) + 1) % (1 << W));
      end
      if (rt || ca || br) m_flush_left = FLUSH;
      else if (m_flush_left > 0) m_flush_left--;
   endtask

   task automatic check_all(input string tag);
      check({tag, ".pc"}, 32'(bus.prog_ctr), 32'(m_pc));
      check({tag, ".inv"}, 32'(bus.set_invalidate_instruction), 32'(m_flush_left != 0));
      check({tag, ".depth"}, 32'(bus.stack_depth), 32'(m_ras.size()));
      check({tag, ".ovf"}, 32'(bus.stack_ovf), 32'(m_ovf));
      check({tag, ".unf"}, 32'(bus.stack_unf), 32'(m_unf));
   endtask

   // Called at a negedge; drives, clocks, updates the model and checks at the next negedge.
   task automatic step(input string tag, input logic st, input logic br, input logic ca,
                       input logic rt, input logic [W-1:0] nxt, input logic [W-1:0] ra);
      bus.stall            = st;
      bus.branch_taken_reg = br;
      bus.call_taken_reg   = ca;
      bus.ret_taken_reg    = rt;
      bus.nxt_prog_ctr_r2  = nxt;
      bus.ret_addr_r2      = ra;
      @(posedge clk);
      model_edge(st, br, ca, rt, nxt, ra);
      @(negedge clk);
      check_all(tag);
   endtask

   task automatic idle(input string tag, input int n);
      for (int i = 0; i < n; i++) step(tag, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
   endtask

   // Asynchronous reset pulse from a negedge; PC must drop before any clock edge.
   task automatic async_reset(input string tag);
      reset = 1'b1;
      #1;
      check({tag, ".pc_now"}, 32'(bus.prog_ctr), 32'(RVEC));
      model_reset();
      check_all(tag);
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [W-1:0] rn, ra;
      logic         st, br, ca, rt;

      reset                = 1'b1;
      bus.stall            = 1'b0;
      bus.branch_taken_reg = 1'b0;
      bus.call_taken_reg   = 1'b0;
      bus.ret_taken_reg    = 1'b0;
      bus.nxt_prog_ctr_r2  = '0;
      bus.ret_addr_r2      = '0;
      model_reset();
      repeat (2) @(negedge clk);
      check_all("reset");
      reset = 1'b0;

      // 1. Free count, then async reset mid-count
      idle("count", 5);
      check("count.pc6", 32'(bus.prog_ctr), 32'd6);
      async_reset("async1");

      // 2. Branch near the top, count through the wrap
      step("branch", 1'b0, 1'b1, 1'b0, 1'b0, 10'h3F0, '0);
      check("branch.pc", 32'(bus.prog_ctr), 32'h3F0);
      idle("wrap", 16);
      check("wrap.pc0", 32'(bus.prog_ctr), 32'h000);

      // 3. Call then return
      step("call", 1'b0, 1'b0, 1'b1, 1'b0, 10'h100, 10'h021);
      check("call.pc", 32'(bus.prog_ctr), 32'h100);
      idle("after_call", 3);
      step("ret", 1'b0, 1'b0, 1'b0, 1'b1, '0, '0);
      check("ret.pc", 32'(bus.prog_ctr), 32'h021);
      idle("after_ret", 3);

      // 5. Stall hold, redirect wins over stall
      step("to50", 1'b0, 1'b1, 1'b0, 1'b0, 10'h050, '0);
      for (int i = 0; i < 3; i++) begin
         step("stall", 1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
         check("stall.hold", 32'(bus.prog_ctr), 32'h050);
      end
      step("stall_br", 1'b1, 1'b1, 1'b0, 1'b0, 10'h0A0, '0);
      check("stall_br.pc", 32'(bus.prog_ctr), 32'h0A0);
      idle("after_stall", 3);

      // 6. Simultaneous ret+call+branch, then branch inside the flush window
      step("push77", 1'b0, 1'b0, 1'b1, 1'b0, 10'h300, 10'h077);
      idle("wait77", 3);
      step("combo", 1'b0, 1'b1, 1'b1, 1'b1, 10'h123, 10'h055);
      check("combo.pc", 32'(bus.prog_ctr), 32'h077);
      check("combo.depth", 32'(bus.stack_depth), 32'd0);
      step("ext_br", 1'b0, 1'b1, 1'b0, 1'b0, 10'h200, '0);
      check("ext_br.inv", 32'(bus.set_invalidate_instruction), 32'd1);
      idle("ext_tail", 3);

      // 4. Overflow with circular overwrite, drain, underflow
      for (int i = 0; i < 5; i++)
         step("ovf_call", 1'b0, 1'b0, 1'b1, 1'b0, W'(10'h200 + i), W'(10'h010 + i));
      check("ovf.flag", 32'(bus.stack_ovf), 32'd1);
      check("ovf.depth", 32'(bus.stack_depth), 32'd4);
      for (int i = 0; i < 4; i++) begin
         step("drain", 1'b0, 1'b0, 1'b0, 1'b1, '0, '0);
         check("drain.pc", 32'(bus.prog_ctr), 32'(10'h014 - i));
      end
      step("unf_ret", 1'b0, 1'b0, 1'b0, 1'b1, '0, '0);
      check("unf.pc", 32'(bus.prog_ctr), 32'(RVEC));
      check("unf.flag", 32'(bus.stack_unf), 32'd1);
      idle("after_unf", 2);

      // Randomized traffic, with an async reset in the middle
      async_reset("async2");
      for (int i = 0; i < 400; i++) begin
         if (i == 200) async_reset("async3");
         st = ($urandom_range(0, 3) == 0);
         br = ($urandom_range(0, 7) == 0);
         ca = ($urandom_range(0, 6) == 0);
         rt = ($urandom_range(0, 7) == 0);
         rn = W'($urandom);
         ra = W'($urandom);
         step("rand", st, br, ca, rt, rn, ra);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
